// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index counter. A single-nibble datapath still gets
    // a 1-bit counter so no zero-width vectors appear.
    function automatic int idx_w(input int nib);
        if (nib <= 1) begin
            return 1;
        end
        return $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operation request / result bundle between issuer, adder and consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on requests, out_valid/out_ready on results.
// master: drives in_valid/in_a/in_b/in_sub/out_ready, observes the rest.
// slave : the adder; drives in_ready and all out_* signals.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/nibble_serial_addsub_rca.sv
// 4-bit ripple-carry adder slice (four_bit_RCA).
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b (4-bit operands), i_cin (carry in) -> o_s (4-bit sum), o_cout.
module four_bit_RCA
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_cout
);
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract done one nibble per clock through a single 4-bit slice.
// Latency: out_valid rises WIDTH/4 cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
// Ports: clk, rst (sync, active-high), bus (slave modport of nibble_serial_addsub_if).
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_w(NIB);
    localparam int MSB = WIDTH - 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_a, r_b, r_s;
    logic [WIDTH-1:0]    w_s_nxt;
    logic                r_sub, r_carry, r_cout, r_ovf, r_zero;
    logic [IW-1:0]       r_idx;
    logic                w_in_rdy, w_out_vld, w_accept, w_last;
    logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_sum;
    logic                w_cin, w_cout, w_ovf;

    // Operand nibbles for the current pass; B is inverted for subtraction
    // before it reaches the plain adder slice.
    assign w_a_nib = r_a[NIBBLE_W*int'(r_idx) +: NIBBLE_W];
    assign w_b_nib = r_b[NIBBLE_W*int'(r_idx) +: NIBBLE_W] ^ {NIBBLE_W{r_sub}};

    // First nibble takes the +1 of two's-complement subtraction from sub;
    // later nibbles chain the registered carry.
    assign w_cin  = (r_idx == '0) ? r_sub : r_carry;
    assign w_last = (r_idx == IW'(NIB - 1));

    four_bit_RCA u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (w_cin),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // Full result with the current nibble merged in, so the zero flag sees
    // the final nibble rather than the stale register contents.
    always_comb begin
        w_s_nxt = r_s;
        w_s_nxt[NIBBLE_W*int'(r_idx) +: NIBBLE_W] = w_sum;
    end

    assign w_ovf = (r_a[MSB] == (r_b[MSB] ^ r_sub)) & (w_sum[NIBBLE_W-1] != r_a[MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_out_vld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_rdy = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_vld = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_rdy & bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_sub   <= bus.in_sub;
            r_carry <= bus.in_sub;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_s     <= w_s_nxt;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_s_nxt == '0);
                r_idx  <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = w_out_vld;
    assign bus.out_s     = r_s;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed vectors plus randomized operations,
// every cycle compared against an arithmetic reference model.
module tb_nibble_serial_addsub;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.WIDTH(W)) bus ();

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        res_t x;
        int   sa, sb, r, ua, ub;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        r   = sub ? (sa - sb) : (sa + sb);
        x.s = r[15:0];
        x.c = sub ? (ua >= ub) : ((ua + ub) > 65535);
        x.o = (r > 32767) || (r < -32768);
        x.z = (x.s == 16'h0000);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle compare against the model's view of the transaction.
    bit   m_armed   = 1'b0;
    bit   m_pending = 1'b0;
    int   m_age     = 0;
    res_t m_exp     = '0;
    res_t m_last    = '0;

    initial begin : cmp
        forever begin
            @(posedge clk);
            if (rst) begin
                m_armed   = 1'b1;
                m_pending = 1'b0;
                m_age     = 0;
                m_last    = '0;
            end else if (m_armed) begin
                if (!m_pending) begin
                    if (bus.in_valid) begin
                        m_pending = 1'b1;
                        m_age     = 0;
                        m_exp     = model(bus.in_a, bus.in_b, bus.in_sub);
                    end
                end else if (m_age < NIB) begin
                    m_age++;
                    if (m_age == NIB) m_last = m_exp;
                end else if (bus.out_ready) begin
                    m_pending = 1'b0;
                end
            end
            #1;
            if (m_armed) begin
                check("cyc_in_ready", 32'(bus.in_ready), 32'(!m_pending));
                check("cyc_out_valid", 32'(bus.out_valid), 32'(m_pending && m_age == NIB));
                if (!m_pending || m_age == NIB)
                    check("cyc_out_s", 32'(bus.out_s), 32'(m_last.s));
                if (m_pending && m_age == NIB) begin
                    check("cyc_cout", 32'(bus.out_cout), 32'(m_last.c));
                    check("cyc_ovf",  32'(bus.out_ovf),  32'(m_last.o));
                    check("cyc_zero", 32'(bus.out_zero), 32'(m_last.z));
                end
            end
        end
    end

    // Issue one operation, optionally stall the result for 'hold' cycles while
    // hammering in_valid and the operand inputs, then complete one handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input int hold, output res_t got, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("op_in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.out_ready = (hold == 0);
        tick();
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            tick();
            lat++;
        end
        check("op_out_valid_seen", 32'(bus.out_valid), 32'd1);
        got.s = bus.out_s;
        got.c = bus.out_cout;
        got.o = bus.out_ovf;
        got.z = bus.out_zero;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            tick();
            check("hold_out_s", 32'(bus.out_s), 32'(got.s));
            check("hold_flags", 32'({bus.out_cout, bus.out_ovf, bus.out_zero}),
                  32'({got.c, got.o, got.z}));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    res_t got, exp_r;
    int   lat;

    initial begin : main
        logic [15:0] ra, rb;
        logic        rs;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // Hand-computed values pin the reference model itself.
        check("pin_add",   32'(model(16'h1234, 16'h0FFF, 1'b0)), 32'({16'h2233, 3'b000}));
        check("pin_sub",   32'(model(16'h0005, 16'h0007, 1'b1)), 32'({16'hFFFE, 3'b000}));
        check("pin_subov", 32'(model(16'h8000, 16'h0001, 1'b1)), 32'({16'h7FFF, 3'b110}));
        check("pin_wrap",  32'(model(16'hFFFF, 16'h0001, 1'b0)), 32'({16'h0000, 3'b101}));

        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_s",     32'(bus.out_s),     32'd0);
        check("rst_flags", 32'({bus.out_cout, bus.out_ovf, bus.out_zero}), 32'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, 0, got, lat);
        check("add_latency", 32'(lat), 32'd4);
        check("add_result", 32'(got), 32'({16'h2233, 3'b000}));
        check("add_ready_back", 32'({bus.in_ready, bus.out_valid}), 32'b10);

        run_op(16'h0005, 16'h0007, 1'b1, 0, got, lat);
        check("sub_borrow", 32'(got), 32'({16'hFFFE, 3'b000}));
        run_op(16'h8000, 16'h0001, 1'b1, 0, got, lat);
        check("sub_ovf", 32'(got), 32'({16'h7FFF, 3'b110}));
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, got, lat);
        check("add_zero", 32'(got), 32'({16'h0000, 3'b101}));

        run_op(16'hA5A5, 16'h1111, 1'b0, 3, got, lat);
        check("bp_result", 32'(got), 32'({16'hB6B6, 3'b000}));
        check("bp_single_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        run_op(16'h0003, 16'h0003, 1'b1, 0, got, lat);
        check("bp_next_op", 32'(got), 32'({16'h0000, 3'b101}));

        // Reset in the middle of RUN discards the partial result.
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h1234;
        bus.in_b      = 16'h0FFF;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_s",     32'(bus.out_s),     32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, got, lat);
        check("post_rst_add", 32'(got), 32'({16'h0100, 3'b000}));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 16'h8000;
                1:       ra = 16'h7FFF;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 16'hFFFF;
                1:       rb = ra;
                default: rb = 16'($urandom);
            endcase
            rs    = 1'($urandom);
            exp_r = model(ra, rb, rs);
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), got, lat);
            check("rand_result", 32'(got), 32'(exp_r));
            check("rand_latency", 32'(lat), 32'(NIB));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1);
    end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Sequential WIDTH-bit adder/subtractor built on the existing 4-bit ripple-carry add/subtract slice.
- Operands are captured once, then processed one nibble per clock, LSB nibble first, through a single slice instance.
- A carry flip-flop links successive nibbles.
- The finished sum/difference and its flags are presented on a valid/ready output port; it sits between the operand-issuing control logic and the result consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration-time check).
- NIB, WIDTH/4, number of nibble passes per operation (derived; not overridden).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_s  out  WIDTH  result.
- out_cout  out  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_s == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_s = 0, out_cout = 0, out_ovf = 0, out_zero = 0, nibble index = 0, carry register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register in_a, in_b and in_sub; carry register <= in_sub; index <= 0; go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle the slice sees A nibble[index], B nibble[index] and the carry register.
  - The slice internally inverts B when sub = 1.
  - On the edge: write the slice sum into result nibble[index]; carry register <= slice Cout; index++.
  - When index == NIB-1, additionally latch out_cout, out_ovf and out_zero, and go to DONE.
- DONE:
  - out_valid = 1; out_s and flags are held stable until the handshake.
  - On out_valid & out_ready, go to IDLE; in_ready is 1 the following cycle.
  - out_s keeps its last value after the handshake; it is not cleared.
- Latency: out_valid rises NIB cycles after the accept edge (4 cycles for WIDTH = 16).
- Throughput: one operation per NIB+2 cycles minimum; no overlap of operations.
- Overflow: ovf = (A[MSB] == Bx[MSB]) & (S[MSB] != A[MSB]), where Bx = B ^ {WIDTH{sub}}. It is evaluated in the final RUN cycle from the registered operands and the final slice sum bit.
- Zero flag: computed on the full WIDTH-bit result including the final nibble, not the stale register.
- Operand inputs may change freely after the accept; the captured copies are used.
- rst asserted in any state, including mid-RUN or DONE with out_ready low:
  - The next cycle shows reset values and the partial result is discarded.
  - A new operation may be accepted the cycle rst deasserts.
- in_valid held high while busy does not start or queue a second operation.
- WIDTH = 4: a single RUN cycle.

Decomposition:
- Shared package:
  - state enum (IDLE/RUN/DONE, 2-bit encoding);
  - constant NIBBLE_W = 4;
  - helper function for index width, clog2(NIB) with a minimum of 1.
- Sub-module: reuse the existing four_bit_RCS as the single nibble slice, with the captured sub driving its Sub input.
  - The carry register is fed to its carry-in position instead of Sub on nibbles after the first; this is handled by a top-level mux.
  - Invert-B stays in the slice.
  - Implementation note: because four_bit_RCS ties carry-in to Sub, instantiate four_bit_RCA with B pre-XORed by sub at the top level.
- No other sub-modules.

Test Plan:
- Add 0x1234 + 0x0FFF, out_ready = 1 → out_valid exactly 4 cycles after accept; out_s = 0x2233, cout = 0, ovf = 0, zero = 0; in_ready back to 1 one cycle later.
- Sub 0x0005 - 0x0007 → out_s = 0xFFFE, cout = 0 (borrow), ovf = 0, zero = 0.
- Sub 0x8000 - 0x0001 → out_s = 0x7FFF, cout = 1, ovf = 1, zero = 0.
- Add 0xFFFF + 0x0001 → out_s = 0x0000, cout = 1, ovf = 0, zero = 1.
- Backpressure and busy stimulus:
  - hold out_ready = 0 for 3 cycles in DONE, toggling in_a/in_b and holding in_valid = 1 → out_s and flags stable, in_ready = 0, no second accept;
  - then raise out_ready → a single handshake; the next operation is accepted only after in_ready returns.
- Assert rst for 1 cycle after 2 RUN cycles of 0x1234 + 0x0FFF → next cycle out_valid = 0, in_ready = 1, out_s = 0; then 0x00FF + 0x0001 → out_s = 0x0100, cout = 0.
